// File: rtl/dldo_switch_array_driver.sv
// dldo_switch_array_driver
//   Takes the 14-bit power-switch code SROUT from the DLDO controller and
//   drives the PMOS switch array gates. The array is split into two parts:
//     - 63 unary segments of 256 LSB each, controlled by code[13:8]
//     - 8 binary-weighted switches, controlled by code[7:0]
//   Before SROUT becomes the target it must be seen on two consecutive
//   samples. Unary segment changes are rate-limited to UNIT_STEP per cycle
//   so that the supply di/dt stays bounded. The binary weights follow the
//   target directly because each one is smaller than a single segment.
//
// Parameters
//   UNIT_STEP   max unary segments changed per CLKD cycle (1..8)
//   SETTLE_CYC  consecutive idle cycles before SETTLED asserts (1..7)
//
// Ports
//   CLKD       in   1   controller clock, rising edge
//   RST        in   1   asynchronous active-high reset (all switches off)
//   SROUT      in   14  target code; bit=1 means the weight is OFF
//   FORCE_OFF  in   1   synchronous emergency all-off
//   PG_UNARY   out  63  unary gate drive; bit i = 1 when i < u_cur (segment off)
//   PG_BIN     out  8   binary gate drive; 1 = switch off
//   CUR_CODE   out  14  applied code {u_cur, PG_BIN}
//   BUSY       out  1   unary ramp still in progress
//   SETTLED    out  1   array has been held at target for SETTLE_CYC cycles
//
// Settle FSM
//   state    | meaning
//   ST_HOLD  | at target, idle counter below SETTLE_CYC
//   ST_RAMP  | unary segments still stepping toward target (BUSY=1)
//   ST_LOCK  | at target for SETTLE_CYC cycles (SETTLED=1)

module dldo_switch_array_driver #(
    parameter int UNIT_STEP  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic        CLKD,
    input  logic        RST,
    input  logic [13:0] SROUT,
    input  logic        FORCE_OFF,
    output logic [62:0] PG_UNARY,
    output logic [7:0]  PG_BIN,
    output logic [13:0] CUR_CODE,
    output logic        BUSY,
    output logic        SETTLED
);

    localparam logic [13:0] CODE_OFF = 14'h3FFF;
    localparam logic [5:0]  U_OFF    = 6'd63;
    localparam logic [5:0]  STEP     = 6'(UNIT_STEP);
    localparam logic [2:0]  CNT_MAX  = 3'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RAMP = 2'b01,
        ST_LOCK = 2'b10
    } state_t;

    logic [13:0] r_s1;
    logic [13:0] r_tgt;
    logic [5:0]  r_u_cur;
    logic [7:0]  r_pg_bin;
    logic [62:0] r_pg_unary;
    logic [2:0]  r_cnt;
    state_t      r_state;

    logic [13:0] w_s1_nxt;
    logic [13:0] w_tgt_nxt;
    logic [5:0]  w_u_nxt;
    logic [7:0]  w_bin_nxt;
    logic [62:0] w_pg_unary_nxt;
    logic [2:0]  w_cnt_nxt;
    state_t      w_state_nxt;

    logic [5:0]  w_u_tgt;
    logic [5:0]  w_up_diff;
    logic [5:0]  w_dn_diff;
    logic [5:0]  w_u_ramp;
    logic        w_tgt_load;
    logic        w_tgt_new;
    logic        w_busy;

    assign w_u_tgt    = r_tgt[13:8];
    assign w_busy     = (r_u_cur != w_u_tgt);
    assign w_tgt_load = (SROUT == r_s1);
    assign w_tgt_new  = w_tgt_load && (SROUT != r_tgt);

    // Step toward the registered target by at most STEP. The step is clamped
    // to the remaining distance, so the ramp lands exactly on the target and
    // u_cur can never leave 0..63.
    always_comb begin
        w_up_diff = w_u_tgt - r_u_cur;
        w_dn_diff = r_u_cur - w_u_tgt;
        w_u_ramp  = r_u_cur;
        if (w_u_tgt > r_u_cur) begin
            w_u_ramp = r_u_cur + ((w_up_diff > STEP) ? STEP : w_up_diff);
        end else if (w_u_tgt < r_u_cur) begin
            w_u_ramp = r_u_cur - ((w_dn_diff > STEP) ? STEP : w_dn_diff);
        end
    end

    // Next-state and datapath update. FORCE_OFF overrides everything else and
    // skips the rate limit, because turning switches off is always safe.
    always_comb begin
        w_s1_nxt    = SROUT;
        w_tgt_nxt   = r_tgt;
        w_u_nxt     = w_u_ramp;
        w_bin_nxt   = r_tgt[7:0];
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;

        if (w_tgt_load) begin
            w_tgt_nxt = SROUT;
        end

        // A ramp in progress, or a freshly accepted target, restarts the
        // settle window. Otherwise the counter saturates at CNT_MAX.
        if (w_busy || w_tgt_new) begin
            w_cnt_nxt = 3'd0;
        end else if (r_cnt < CNT_MAX) begin
            w_cnt_nxt = r_cnt + 3'd1;
        end

        if (FORCE_OFF) begin
            w_s1_nxt  = CODE_OFF;
            w_tgt_nxt = CODE_OFF;
            w_u_nxt   = U_OFF;
            w_bin_nxt = 8'hFF;
            w_cnt_nxt = 3'd0;
        end

        // The state is a function of the values that will be registered, so
        // SETTLED comes straight from a flop.
        if (w_u_nxt != w_tgt_nxt[13:8]) begin
            w_state_nxt = ST_RAMP;
        end else if (w_cnt_nxt == CNT_MAX) begin
            w_state_nxt = ST_LOCK;
        end else begin
            w_state_nxt = ST_HOLD;
        end
    end

    // The gate drive is registered from the next u_cur so the array pins
    // come straight off flops and never glitch during decode.
    always_comb begin
        w_pg_unary_nxt = '0;
        for (int i = 0; i < 63; i++) begin
            w_pg_unary_nxt[i] = (6'(i) < w_u_nxt);
        end
    end

    always_ff @(posedge CLKD or posedge RST) begin
        if (RST) begin
            r_s1       <= CODE_OFF;
            r_tgt      <= CODE_OFF;
            r_u_cur    <= U_OFF;
            r_pg_bin   <= 8'hFF;
            r_pg_unary <= '1;
            r_cnt      <= 3'd0;
            r_state    <= ST_HOLD;
        end else begin
            r_s1       <= w_s1_nxt;
            r_tgt      <= w_tgt_nxt;
            r_u_cur    <= w_u_nxt;
            r_pg_bin   <= w_bin_nxt;
            r_pg_unary <= w_pg_unary_nxt;
            r_cnt      <= w_cnt_nxt;
            r_state    <= w_state_nxt;
        end
    end

    assign PG_UNARY = r_pg_unary;
    assign PG_BIN   = r_pg_bin;
    assign CUR_CODE = {r_u_cur, r_pg_bin};
    assign BUSY     = w_busy;
    assign SETTLED  = (r_state == ST_LOCK);

endmodule
